// File: rtl/turf_trig_source_arb.sv
// Trigger-source arbiter: merges NUM_SRC level sources into one trigger stream.
// Each source goes through rising-edge detection, an enable mask and a prescaler.
// An accepted trigger is held with valid/type until the buffer manager acks it.
// A programmable holdoff follows each ack. Accepted triggers are counted, and so
// are cycles whose qualified edges had to be discarded.
module turf_trig_source_arb #(
  parameter int NUM_SRC       = 4,
  parameter int PRESCALE_BITS = 8,
  parameter int HOLDOFF_BITS  = 8,
  parameter int LOST_BITS     = 16
) (
  input  logic                              clk250_i,
  input  logic                              rst_i,
  input  logic [NUM_SRC-1:0]                src_i,
  input  logic [NUM_SRC-1:0]                en_mask_i,
  input  logic [NUM_SRC*PRESCALE_BITS-1:0]  prescale_i,
  input  logic [HOLDOFF_BITS-1:0]           holdoff_i,
  input  logic                              disable_i,
  input  logic                              clr_i,
  output logic                              trig_valid_o,
  output logic [NUM_SRC-1:0]                trig_type_o,
  input  logic                              trig_ack_i,
  output logic [31:0]                       trig_count_o,
  output logic [LOST_BITS-1:0]              lost_cnt_o
);

  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;

  // Source sample and edge history. Both reset to all ones so that a source
  // already high when reset is released does not look like a rising edge.
  logic [NUM_SRC-1:0] src_reg;
  logic [NUM_SRC-1:0] prev_reg;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] hit;
  logic [NUM_SRC-1:0] qual;

  state_t                  state_reg, state_next;
  logic [HOLDOFF_BITS-1:0] hold_reg, hold_next;
  logic                    valid_reg, valid_next;
  logic [NUM_SRC-1:0]      type_reg, type_next;
  logic [31:0]             count_reg, count_next, count_base;
  logic [LOST_BITS-1:0]    lost_reg, lost_next, lost_base;

  // Register the source levels and keep one cycle of history for edge detection.
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      src_reg  <= '1;
      prev_reg <= '1;
    end else begin
      src_reg  <= src_i;
      prev_reg <= src_reg;
    end
  end

  assign edge_det = src_reg & ~prev_reg;

  // One prescaler per source; it runs on every enabled edge regardless of the
  // arbiter state or the master disable, so the pass ratio is never disturbed.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_prescale
      logic [PRESCALE_BITS-1:0] cnt_reg;
      logic [PRESCALE_BITS-1:0] limit;

      assign limit   = prescale_i[gi*PRESCALE_BITS +: PRESCALE_BITS];
      assign hit[gi] = edge_det[gi] && (cnt_reg == limit);

      // Count enabled edges; wrap to zero on a hit, clear has priority.
      always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_reg <= '0;
        end else if (clr_i) begin
          cnt_reg <= '0;
        end else if (edge_det[gi] && en_mask_i[gi]) begin
          cnt_reg <= hit[gi] ? '0 : cnt_reg + PRESCALE_BITS'(1);
        end
      end
    end
  endgenerate

  assign qual = edge_det & en_mask_i & hit & {NUM_SRC{~disable_i}};

  // Arbiter state, holdoff counter, outputs and counters.
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      valid_reg <= 1'b0;
      type_reg  <= '0;
      count_reg <= '0;
      lost_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      valid_reg <= valid_next;
      type_reg  <= type_next;
      count_reg <= count_next;
      lost_reg  <= lost_next;
    end
  end

  // Next-state logic. A clear is applied to the counters before any increment
  // in the same cycle, so a clear coinciding with an accept leaves a count of 1.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    valid_next = valid_reg;
    type_next  = type_reg;
    count_base = clr_i ? 32'd0 : count_reg;
    lost_base  = clr_i ? '0 : lost_reg;
    count_next = count_base;
    lost_next  = lost_base;

    case (state_reg)
      IDLE: begin
        if (|qual) begin
          valid_next = 1'b1;
          type_next  = qual;
          state_next = PEND;
          count_next = count_base + 32'd1;
        end
      end
      PEND: begin
        if (trig_ack_i) begin
          valid_next = 1'b0;
          type_next  = '0;
          hold_next  = holdoff_i;
          state_next = (holdoff_i == '0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (hold_reg <= HOLDOFF_BITS'(1)) begin
          state_next = IDLE;
        end else begin
          hold_next = hold_reg - HOLDOFF_BITS'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Any qualified edge while busy is one lost cycle, however many bits fired.
    if ((state_reg != IDLE) && (|qual) && (lost_base != '1)) begin
      lost_next = lost_base + LOST_BITS'(1);
    end
  end

  assign trig_valid_o = valid_reg;
  assign trig_type_o  = type_reg;
  assign trig_count_o = count_reg;
  assign lost_cnt_o   = lost_reg;

endmodule

// File: tb/tb_turf_trig_source_arb.sv
// Directed bench for the trigger-source arbiter with a cycle model and
// per-cycle comparison, plus hand-computed checkpoints for each scenario.
module tb_turf_trig_source_arb;

  localparam int NS = 4;
  localparam int PB = 8;
  localparam int HB = 8;
  localparam int LB = 4;
  localparam int LOST_MAX = (1 << LB) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     src;
  logic [NS-1:0]     en_mask;
  logic [NS*PB-1:0]  prescale;
  logic [HB-1:0]     holdoff;
  logic              dis;
  logic              clr;
  logic              ack;
  logic              valid;
  logic [NS-1:0]     ttype;
  logic [31:0]       count;
  logic [LB-1:0]     lost;

  int tests = 0;
  int errors = 0;

  turf_trig_source_arb #(
    .NUM_SRC(NS), .PRESCALE_BITS(PB), .HOLDOFF_BITS(HB), .LOST_BITS(LB)
  ) dut (
    .clk250_i(clk), .rst_i(rst), .src_i(src), .en_mask_i(en_mask),
    .prescale_i(prescale), .holdoff_i(holdoff), .disable_i(dis), .clr_i(clr),
    .trig_valid_o(valid), .trig_type_o(ttype), .trig_ack_i(ack),
    .trig_count_o(count), .lost_cnt_o(lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sources seen one and two edges ago; "busy" means a trigger is pending or
  // holdoff cycles remain.
  logic [NS-1:0] m_s1, m_s2;
  int            m_pcnt [NS];
  bit            m_pend;
  int            m_hold;
  logic [NS-1:0] m_type;
  int unsigned   m_count;
  int            m_lost;

  always @(posedge clk or posedge rst) begin : model
    logic [NS-1:0] e;
    logic [NS-1:0] q;
    int            nc [NS];
    int unsigned   cnt_v;
    int            lost_v;
    if (rst) begin
      m_s1    <= '1;
      m_s2    <= '1;
      for (int k = 0; k < NS; k++) m_pcnt[k] <= 0;
      m_pend  <= 1'b0;
      m_hold  <= 0;
      m_type  <= '0;
      m_count <= 0;
      m_lost  <= 0;
    end else begin
      e      = m_s1 & ~m_s2;
      q      = '0;
      cnt_v  = clr ? 0 : m_count;
      lost_v = clr ? 0 : m_lost;
      for (int k = 0; k < NS; k++) begin
        nc[k] = m_pcnt[k];
        if (e[k] && en_mask[k]) begin
          if (m_pcnt[k] == int'(prescale[k*PB +: PB])) begin
            q[k]  = ~dis;
            nc[k] = 0;
          end else begin
            nc[k] = (m_pcnt[k] + 1) % (1 << PB);
          end
        end
        if (clr) nc[k] = 0;
        m_pcnt[k] <= nc[k];
      end
      if (m_pend || m_hold > 0) begin
        if (q != 0 && lost_v < LOST_MAX) lost_v = lost_v + 1;
        if (m_pend) begin
          if (ack) begin
            m_pend <= 1'b0;
            m_hold <= int'(holdoff);
          end
        end else begin
          m_hold <= m_hold - 1;
        end
      end else if (q != 0) begin
        m_pend <= 1'b1;
        m_type <= q;
        cnt_v  = cnt_v + 1;
      end
      m_count <= cnt_v;
      m_lost  <= lost_v;
      m_s2    <= m_s1;
      m_s1    <= src;
    end
  end

  // Compare DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("model_valid", valid, m_pend);
      if (m_pend) check("model_type", ttype, m_type);
      check("model_count", count, m_count);
      check("model_lost", lost, m_lost);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NS-1:0] m);
    @(negedge clk); src = m;
    @(negedge clk); src = '0;
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  // Assumes the caller sits on a falling edge with a trigger pending.
  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, valid, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int fires;
    int bad_idx;
    rst = 1'b1; src = '0; en_mask = '0; prescale = '0; holdoff = '0;
    dis = 1'b0; clr = 1'b0; ack = 1'b0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_type", ttype, 0);
    check("reset_count", count, 0);
    check("reset_lost", lost, 0);

    // 1: single pulse on source 1, valid two clocks after the source rises
    en_mask = 4'b0010;
    pulse(4'b0010);
    check("t1_not_yet", valid, 0);
    @(negedge clk);
    check("t1_valid", valid, 1);
    check("t1_type", ttype, 4'b0010);
    check("t1_count", count, 1);
    do_ack();
    @(negedge clk);
    check("t1_acked", valid, 0);

    // 2: sources 0 and 2 together give one trigger
    en_mask = 4'b1111;
    do_clr();
    pulse(4'b0101);
    wait_valid("t2_valid");
    check("t2_type", ttype, 4'b0101);
    check("t2_count", count, 1);
    check("t2_lost", lost, 0);
    do_ack();

    // 3: prescale 3 on source 0 passes the 4th and 8th edges
    do_clr();
    en_mask = 4'b0001;
    prescale = {8'd0, 8'd0, 8'd0, 8'd3};
    fires = 0;
    bad_idx = 0;
    for (int i = 0; i < 8; i++) begin
      pulse(4'b0001);
      @(negedge clk);
      if (valid) begin
        fires++;
        if (i != 3 && i != 7) bad_idx++;
        do_ack();
      end
    end
    check("t3_fires", fires, 2);
    check("t3_fire_positions", bad_idx, 0);
    check("t3_count", count, 2);

    // 4: holdoff 10; pulse 5 cycles after ack is lost, 12 cycles after is taken
    prescale = '0;
    en_mask = 4'b1111;
    do_clr();
    pulse(4'b1000);
    wait_valid("t4_valid");
    holdoff = 8'd10;
    do_ack();
    tick(3);
    pulse(4'b1000);
    tick(5);
    pulse(4'b1000);
    @(negedge clk);
    check("t4_second_valid", valid, 1);
    check("t4_lost", lost, 1);
    check("t4_count", count, 2);
    holdoff = 8'd0;
    do_ack();

    // 5: ack withheld while three pulses arrive; disable does not withdraw
    do_clr();
    pulse(4'b0001);
    wait_valid("t5_valid");
    for (int j = 0; j < 3; j++) begin
      pulse(4'b0010);
      tick(3);
    end
    dis = 1'b1;
    pulse(4'b0100);
    tick(2);
    check("t5_valid_held", valid, 1);
    check("t5_type_held", ttype, 4'b0001);
    check("t5_lost", lost, 3);
    dis = 1'b0;
    do_ack();

    // 6: lost counter saturates at all ones
    do_clr();
    pulse(4'b0001);
    wait_valid("t6_valid");
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      src = (j % 2 == 1) ? 4'b1010 : 4'b0101;
    end
    @(negedge clk); src = '0;
    tick(2);
    check("t6_lost_sat", lost, LOST_MAX);
    do_ack();
    tick(2);

    // 7: clear coinciding with an accept leaves count at 1
    @(negedge clk); src = 4'b0100;
    @(negedge clk); src = '0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("t7_valid", valid, 1);
    check("t7_count", count, 1);
    check("t7_lost", lost, 0);
    do_ack();

    // 8: async reset mid-PEND, then a source held high through reset release
    pulse(4'b0010);
    wait_valid("t8_valid");
    #2 rst = 1'b1;
    #1;
    check("t8_rst_valid", valid, 0);
    check("t8_rst_type", ttype, 0);
    check("t8_rst_count", count, 0);
    src = 4'b1111;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    tick(6);
    check("t8_high_at_release", valid, 0);
    check("t8_count_after", count, 0);
    src = '0;
    tick(2);
    pulse(4'b0001);
    @(negedge clk);
    check("t8_rearmed", valid, 1);
    check("t8_rearm_count", count, 1);
    do_ack();
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
